// File: rtl/byte_demux_oct.sv
// Registered 1-to-8 byte distributor: steers D_i into one of eight held output
// registers, either by explicit select or by an auto-incrementing fill pointer.
module byte_demux_oct #(
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic       Clk_i,
    input  logic       Reset_i,
    input  logic [7:0] D_i,
    input  logic       Strobe_i,
    input  logic [2:0] Sel_i,
    input  logic       Mode_i,
    input  logic       Start_i,
    input  logic       Clear_i,
    output logic [7:0] Y0_o,
    output logic [7:0] Y1_o,
    output logic [7:0] Y2_o,
    output logic [7:0] Y3_o,
    output logic [7:0] Y4_o,
    output logic [7:0] Y5_o,
    output logic [7:0] Y6_o,
    output logic [7:0] Y7_o,
    output logic [7:0] Written_o,
    output logic       Busy_o,
    output logic       Done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  ptr_q, ptr_d;
    logic [7:0]  written_q, written_d;
    logic        done_q, done_d;
    logic        wr_en;
    logic [2:0]  wr_sel;
    logic [7:0]  y_q [8];

    // Clear and Start both swallow a same-cycle strobe, so writes are only
    // considered once neither control input is active.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        written_d = written_q;
        done_d    = 1'b0;
        wr_en     = 1'b0;
        wr_sel    = ptr_q;

        if (Clear_i) begin
            written_d = '0;
            ptr_d     = '0;
            state_d   = IDLE;
        end else if (Start_i) begin
            written_d = '0;
            ptr_d     = '0;
            state_d   = FILL;
        end else if (Strobe_i) begin
            case (state_q)
                FILL: begin
                    wr_en  = 1'b1;
                    wr_sel = ptr_q;
                    ptr_d  = ptr_q + 3'd1;
                    if (ptr_q == 3'd7) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    if (!Mode_i) begin
                        wr_en  = 1'b1;
                        wr_sel = Sel_i;
                    end
                end
            endcase
            if (wr_en) begin
                written_d = written_q | (8'h01 << wr_sel);
            end
        end
    end

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            written_q <= '0;
            done_q    <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) begin
                y_q[i] <= RESET_VAL;
            end
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            written_q <= written_d;
            done_q    <= done_d;
            if (wr_en) begin
                y_q[wr_sel] <= D_i;
            end
        end
    end

    assign Y0_o      = y_q[0];
    assign Y1_o      = y_q[1];
    assign Y2_o      = y_q[2];
    assign Y3_o      = y_q[3];
    assign Y4_o      = y_q[4];
    assign Y5_o      = y_q[5];
    assign Y6_o      = y_q[6];
    assign Y7_o      = y_q[7];
    assign Written_o = written_q;
    assign Busy_o    = (state_q == FILL);
    assign Done_o    = done_q;

endmodule

// File: tb/tb_byte_demux_oct.sv
// Directed bench for byte_demux_oct: two instances (default and 8'h5A reset
// value) share all inputs; expected values are hand-computed constants.
module tb_byte_demux_oct;

    logic       Clk_i = 1'b0;
    logic       Reset_i = 1'b0;
    logic [7:0] D_i = '0;
    logic       Strobe_i = 1'b0;
    logic [2:0] Sel_i = '0;
    logic       Mode_i = 1'b0;
    logic       Start_i = 1'b0;
    logic       Clear_i = 1'b0;

    logic [7:0] y0a, y1a, y2a, y3a, y4a, y5a, y6a, y7a, wa;
    logic [7:0] y0b, y1b, y2b, y3b, y4b, y5b, y6b, y7b, wb;
    logic       busy_a, done_a, busy_b, done_b;

    int checks = 0;
    int errors = 0;

    always #5 Clk_i = ~Clk_i;

    byte_demux_oct dut_a (
        .Clk_i(Clk_i), .Reset_i(Reset_i), .D_i(D_i), .Strobe_i(Strobe_i),
        .Sel_i(Sel_i), .Mode_i(Mode_i), .Start_i(Start_i), .Clear_i(Clear_i),
        .Y0_o(y0a), .Y1_o(y1a), .Y2_o(y2a), .Y3_o(y3a),
        .Y4_o(y4a), .Y5_o(y5a), .Y6_o(y6a), .Y7_o(y7a),
        .Written_o(wa), .Busy_o(busy_a), .Done_o(done_a)
    );

    byte_demux_oct #(.RESET_VAL(8'h5A)) dut_b (
        .Clk_i(Clk_i), .Reset_i(Reset_i), .D_i(D_i), .Strobe_i(Strobe_i),
        .Sel_i(Sel_i), .Mode_i(Mode_i), .Start_i(Start_i), .Clear_i(Clear_i),
        .Y0_o(y0b), .Y1_o(y1b), .Y2_o(y2b), .Y3_o(y3b),
        .Y4_o(y4b), .Y5_o(y5b), .Y6_o(y6b), .Y7_o(y7b),
        .Written_o(wb), .Busy_o(busy_b), .Done_o(done_b)
    );

    wire [63:0] ya = {y7a, y6a, y5a, y4a, y3a, y2a, y1a, y0a};
    wire [63:0] yb = {y7b, y6b, y5b, y4b, y3b, y2b, y1b, y0b};

    task automatic tick();
        @(posedge Clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        Reset_i  = 1'b0;
        Strobe_i = 1'b0;
        Start_i  = 1'b0;
        Clear_i  = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [7:0] d, input logic [2:0] sel, input logic mode);
        D_i = d; Sel_i = sel; Mode_i = mode; Strobe_i = 1'b1;
        tick();
        idle_inputs();
    endtask

    logic [7:0] exp_w   [8] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
    int         gap     [8] = '{0, 2, 1, 3, 0, 1, 2, 0};

    initial begin
        // Reset
        #1;
        Reset_i = 1'b1;
        tick();
        idle_inputs();
        chk("reset_y_a", ya, 64'h0000_0000_0000_0000);
        chk("reset_y_b", yb, 64'h5A5A_5A5A_5A5A_5A5A);
        chk("reset_written", {wb, wa}, 16'h0000);
        chk("reset_busy_done", {busy_b, done_b, busy_a, done_a}, 4'b0000);

        // Addressed writes
        strobe(8'hA5, 3'd5, 1'b0);
        chk("addr5_y_a", ya, 64'h0000_A500_0000_0000);
        chk("addr5_y_b", yb, 64'h5A5A_A55A_5A5A_5A5A);
        chk("addr5_written", wa, 8'h20);
        chk("addr5_busy", busy_a, 1'b0);
        strobe(8'h3C, 3'd0, 1'b0);
        chk("addr0_y", ya, 64'h0000_A500_0000_003C);
        chk("addr0_written", wa, 8'h21);
        strobe(8'h77, 3'd5, 1'b0);
        chk("rewrite5_y", ya, 64'h0000_7700_0000_003C);
        chk("rewrite5_written", wa, 8'h21);

        // Mode_i=1 in IDLE: strobe ignored
        strobe(8'hFF, 3'd2, 1'b1);
        chk("mode1_idle_y", ya, 64'h0000_7700_0000_003C);
        chk("mode1_idle_written", wa, 8'h21);
        chk("mode1_idle_busy", busy_a, 1'b0);

        // Start with same-cycle strobe: enters FILL, no write
        Mode_i = 1'b0; Start_i = 1'b1; Strobe_i = 1'b1; D_i = 8'hEE; Sel_i = 3'd1;
        tick();
        idle_inputs();
        chk("start_busy", busy_a, 1'b1);
        chk("start_written", wa, 8'h00);
        chk("start_y", ya, 64'h0000_7700_0000_003C);

        // Sequential fill with gaps; Sel_i/Mode_i wiggle and must be ignored
        for (int n = 0; n < 8; n++) begin
            for (int g = 0; g < gap[n]; g++) begin
                Sel_i  = 3'($urandom_range(0, 7));
                Mode_i = ~Mode_i;
                tick();
                chk("fill_gap_busy", busy_a, 1'b1);
                chk("fill_gap_written", wa, (n == 0) ? 8'h00 : exp_w[n-1]);
            end
            strobe(8'h10 + 8'(n), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            chk("fill_written", wa, exp_w[n]);
            if (n < 7) begin
                chk("fill_busy_done", {busy_a, done_a}, 2'b10);
            end
        end
        chk("fill_done_pulse", {busy_a, done_a}, 2'b01);
        chk("fill_y", ya, 64'h1716_1514_1312_1110);
        Mode_i = 1'b0;
        tick();
        chk("done_one_cycle", {busy_a, done_a}, 2'b00);
        chk("done_written_hold", wa, 8'hFF);

        // Addressed write while in DONE
        strobe(8'h99, 3'd3, 1'b0);
        chk("done_addr_y", ya, 64'h1716_1514_9912_1110);
        chk("done_addr_written", wa, 8'hFF);
        chk("done_addr_pulse", done_a, 1'b0);

        // Clear+Start+Strobe in FILL
        Start_i = 1'b1;
        tick();
        idle_inputs();
        strobe(8'h20, 3'd6, 1'b0);
        chk("refill_first", ya, 64'h1716_1514_9912_1120);
        chk("refill_written", wa, 8'h01);
        Clear_i = 1'b1; Start_i = 1'b1; Strobe_i = 1'b1; D_i = 8'h55;
        tick();
        idle_inputs();
        chk("clear_prio_busy_done", {busy_a, done_a}, 2'b00);
        chk("clear_prio_written", wa, 8'h00);
        chk("clear_prio_y", ya, 64'h1716_1514_9912_1120);

        // Start+Strobe from IDLE: pointer restarts at 0
        Start_i = 1'b1; Strobe_i = 1'b1; D_i = 8'h44;
        tick();
        idle_inputs();
        chk("start2_busy", busy_a, 1'b1);
        chk("start2_y", ya, 64'h1716_1514_9912_1120);
        strobe(8'h30, 3'd4, 1'b0);
        strobe(8'h31, 3'd4, 1'b0);
        strobe(8'h32, 3'd4, 1'b0);
        chk("partial_y", ya, 64'h1716_1514_9932_3130);
        chk("partial_written", {wb, wa}, 16'h0707);

        // Reset mid-fill
        Reset_i = 1'b1; Strobe_i = 1'b1; D_i = 8'h33;
        tick();
        idle_inputs();
        chk("midreset_y_a", ya, 64'h0000_0000_0000_0000);
        chk("midreset_y_b", yb, 64'h5A5A_5A5A_5A5A_5A5A);
        chk("midreset_written", {wb, wa}, 16'h0000);
        chk("midreset_busy_done", {busy_b, done_b, busy_a, done_a}, 4'b0000);
        tick();
        chk("midreset_no_done", {done_b, done_a}, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
